cen_fracgen: RTL and testbench
==============================

// Module: cen_fracgen
// PURPOSE
//  Multi-channel fractional clock-enable generator; parametrised successor to the fixed 24 MHz divider.
//  Derives N single-cycle enables from clk_sys, each at exact ratio NUM/DEN with no long-term drift.
//  Adds runtime speed multiplier (fast simulation), per-channel pause freeze and phase resync.
//  Sits at emu level; its cen outputs feed system's ce_* inputs.
// PARAMETERS
//  CHANNELS    2                  number of enable outputs
//  ACC_W       8                  accumulator/ratio field width, bits
//  NUM         {8'd1,8'd1}        packed CHANNELS*ACC_W; ch i numerator = NUM[i*ACC_W +: ACC_W]
//  DEN         {8'd12,8'd4}       packed CHANNELS*ACC_W; ch i denominator (ch0=cen6, ch1=cen2 @24 MHz)
//  PAUSE_MASK  {CHANNELS{1'b1}}   bit i set: channel i freezes while pause=1
// PORTS
//  clk_sys  in   1         system clock; the only clock
//  reset    in   1         synchronous, active-high
//  pause    in   1         freeze channels selected by PAUSE_MASK
//  speed    in   2         rate multiplier 2^speed (0=x1 .. 3=x8)
//  resync   in   1         synchronous phase realign of all channels
//  cen      out  CHANNELS  one-clk_sys-wide enable pulses, registered
// BEHAVIOUR
//  - Legal parameters: 1 <= NUM_i <= DEN_i < 2^ACC_W. Internal sums are ACC_W+4 bits; no overflow.
//  - Per channel i: step = min(NUM_i << speed, DEN_i); sum = acc_i + step.
//    If sum >= DEN_i: acc_i <= sum - DEN_i and cen[i] <= 1; else acc_i <= sum and cen[i] <= 0.
//  - Invariant: acc_i < DEN_i always. step = DEN_i -> cen[i] high every cycle (saturation).
//  - cen is registered: a pulse is high for the cycle after the crossing edge. Never wider than
//    one cycle unless saturated.
//  - Priority per edge: reset > resync > freeze > run.
//  - reset=1: all acc_i <= 0, cen <= 0. All outputs reset to 0. Valid mid-operation; no pulse
//    completes.
//  - resync=1 (reset=0): all acc_i <= 0, cen <= 0, including frozen channels.
//  - Freeze (pause=1 and PAUSE_MASK[i]): acc_i held, cen[i] <= 0.
//    On release, accumulation resumes from the held phase; no pulse is lost or duplicated.
//  - Unmasked channels ignore pause entirely.
//  - speed is sampled every edge. A change takes effect on the next accumulation; acc_i is not
//    cleared.
//  - First pulse after reset/resync release, speed=0: cen[i] registered on edge ceil(DEN_i/NUM_i).
//    Edge 1 = first edge with reset=0.
//  - No state machine beyond the accumulators; no combinational path from inputs to cen.
// TESTING
//  1. Defaults, speed=0, 1200 cycles -> ch0 pulses every 4 edges (first at edge 4), total 300;
//     ch1 every 12, total 100.
//  2. speed=1 -> ch0 period 2, ch1 period 6.
//     speed=3 -> ch0 high every cycle; ch1 pattern 0,1,1 repeating, 800 pulses / 1200 cycles.
//  3. PAUSE_MASK=2'b10, pause high 50 cycles mid-run -> ch1 low, acc1 frozen; ch0 unaffected.
//     After release ch1 next pulse at 12 - (edges already accumulated).
//  4. resync pulse at arbitrary phase -> cen=0 next cycle; ch0 pulse 4 edges later.
//     resync with pause together -> accumulators still cleared.
//     reset mid-pulse -> cen=0, restart per test 1.
//  5. CHANNELS=3, ch2 NUM=3 DEN=8, 8000 cycles -> exactly 3000 ch2 pulses, never two adjacent.
//     Drift = 0 vs. ideal count.
//  6. Random speed/pause/resync soak against reference model -> cycle-exact cen match;
//     acc_i < DEN_i always.

Source files
------------

// File: rtl/cen_fracgen.sv
// rtl/cen_fracgen.sv - multi-channel fractional clock-enable generator
module cen_fracgen #(
  parameter int                          CHANNELS   = 2,
  parameter int                          ACC_W      = 8,
  parameter logic [CHANNELS*ACC_W-1:0]   NUM        = {8'd1, 8'd1},
  parameter logic [CHANNELS*ACC_W-1:0]   DEN        = {8'd12, 8'd4},
  parameter logic [CHANNELS-1:0]         PAUSE_MASK = {CHANNELS{1'b1}}
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                pause,
  input  logic [1:0]          speed,
  input  logic                resync,
  output logic [CHANNELS-1:0] cen
);

  // Four guard bits hold NUM << 3 and acc + step without overflow.
  localparam int SUM_W = ACC_W + 4;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic             cen_q;
    logic [SUM_W-1:0] num_ext;
    logic [SUM_W-1:0] den_ext;
    logic [SUM_W-1:0] shifted;
    logic [SUM_W-1:0] step;
    logic [SUM_W-1:0] sum;
    logic             frozen;

    assign num_ext = SUM_W'(NUM[i*ACC_W +: ACC_W]);
    assign den_ext = SUM_W'(DEN[i*ACC_W +: ACC_W]);

    // A step equal to DEN saturates the channel at one pulse per cycle.
    assign shifted = num_ext << speed;
    assign step    = (shifted > den_ext) ? den_ext : shifted;
    assign sum     = SUM_W'(acc) + step;
    assign frozen  = pause & PAUSE_MASK[i];

    // Phase accumulator: reset > resync > freeze > run; acc stays below DEN.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        acc   <= '0;
        cen_q <= 1'b0;
      end else if (resync) begin
        acc   <= '0;
        cen_q <= 1'b0;
      end else if (frozen) begin
        cen_q <= 1'b0;
      end else if (sum >= den_ext) begin
        acc   <= ACC_W'(sum - den_ext);
        cen_q <= 1'b1;
      end else begin
        acc   <= ACC_W'(sum);
        cen_q <= 1'b0;
      end
    end

    assign cen[i] = cen_q;
  end

endmodule

// File: tb/tb_cen_fracgen.sv
// tb/tb_cen_fracgen.sv - scoreboard bench for cen_fracgen against a phase model
module tb_cen_fracgen;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       pause   = 1'b0;
  logic [1:0] speed   = 2'd0;
  logic       resync  = 1'b0;
  logic [1:0] cen_a;
  logic [2:0] cen_b;

  always #5 clk_sys = ~clk_sys;

  cen_fracgen dut_a (
    .clk_sys (clk_sys),
    .reset   (reset),
    .pause   (pause),
    .speed   (speed),
    .resync  (resync),
    .cen     (cen_a)
  );

  cen_fracgen #(
    .CHANNELS   (3),
    .ACC_W      (8),
    .NUM        ({8'd3, 8'd1, 8'd1}),
    .DEN        ({8'd8, 8'd12, 8'd4}),
    .PAUSE_MASK (3'b010)
  ) dut_b (
    .clk_sys (clk_sys),
    .reset   (reset),
    .pause   (pause),
    .speed   (speed),
    .resync  (resync),
    .cen     (cen_b)
  );

  // Model channels 0..1 are dut_a ch0..1, 2..4 are dut_b ch0..2.
  int nums [5] = '{1, 1, 1, 1, 3};
  int dens [5] = '{4, 12, 4, 12, 8};
  int msk  [5] = '{1, 1, 0, 1, 0};
  int phase[5] = '{0, 0, 0, 0, 0};

  logic [4:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  int cnt  [5];
  int first[5];
  int edges;
  int adj2;
  logic prev_b2;

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 5; k++) begin
      cnt[k]   = 0;
      first[k] = 0;
    end
    edges   = 0;
    adj2    = 0;
    prev_b2 = 1'b0;
  endtask

  // One cycle of stimulus; the model tracks unbounded phase and a pulse is
  // due whenever the phase crosses a new multiple of DEN.
  task automatic cyc(input logic r, input logic rs, input logic p, input logic [1:0] sp);
    logic [4:0] e;
    int st;
    @(negedge clk_sys);
    reset  = r;
    resync = rs;
    pause  = p;
    speed  = sp;
    e = '0;
    for (int k = 0; k < 5; k++) begin
      if (r || rs) begin
        phase[k] = 0;
      end else if (!(p && msk[k] != 0)) begin
        st = nums[k] * (1 << sp);
        if (st > dens[k]) st = dens[k];
        e[k] = ((phase[k] + st) / dens[k]) != (phase[k] / dens[k]);
        phase[k] += st;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 10) begin
      @(posedge clk_sys);
      #2;
      t++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: one expected vector per clock edge, compared after the edge.
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk_sys);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 2;
        if (cen_a !== e[1:0]) begin
          errors++;
          $display("FAIL cen_a t=%0t actual=%b required=%b", $time, cen_a, e[1:0]);
        end
        if (cen_b !== e[4:2]) begin
          errors++;
          $display("FAIL cen_b t=%0t actual=%b required=%b", $time, cen_b, e[4:2]);
        end
        edges++;
        for (int k = 0; k < 5; k++) begin
          if ({cen_b, cen_a}[k] === 1'b1) begin
            cnt[k]++;
            if (first[k] == 0) first[k] = edges;
          end
        end
        if (cen_b[2] === 1'b1 && prev_b2) adj2++;
        prev_b2 = (cen_b[2] === 1'b1);
      end
    end
  end

  initial begin
    logic p;
    logic [1:0] sp;
    clear_counts();

    // Reset state and nominal ratios at speed 0.
    for (int n = 0; n < 3; n++) cyc(1, 0, 0, 0);
    drain();
    check_int("reset_cen_a", int'(cen_a), 0);
    check_int("reset_cen_b", int'(cen_b), 0);
    clear_counts();
    for (int n = 0; n < 1200; n++) cyc(0, 0, 0, 0);
    drain();
    check_int("s0_cnt_a0", cnt[0], 300);
    check_int("s0_cnt_a1", cnt[1], 100);
    check_int("s0_cnt_b2", cnt[4], 450);
    check_int("s0_first_a0", first[0], 4);
    check_int("s0_first_a1", first[1], 12);
    check_int("s0_first_b2", first[4], 3);
    check_int("s0_adjacent_b2", adj2, 0);

    // Speed x2.
    cyc(0, 1, 0, 1);
    drain();
    clear_counts();
    for (int n = 0; n < 1200; n++) cyc(0, 0, 0, 1);
    drain();
    check_int("s1_cnt_a0", cnt[0], 600);
    check_int("s1_cnt_a1", cnt[1], 200);
    check_int("s1_cnt_b2", cnt[4], 900);

    // Speed x8: ch0 saturates, ch1 gives 2 pulses in 3.
    cyc(0, 1, 0, 3);
    drain();
    clear_counts();
    for (int n = 0; n < 1200; n++) cyc(0, 0, 0, 3);
    drain();
    check_int("s3_cnt_a0", cnt[0], 1200);
    check_int("s3_cnt_a1", cnt[1], 800);
    check_int("s3_cnt_b2", cnt[4], 1200);

    // Pause mid-phase: masked channels resume from the held phase.
    cyc(0, 1, 0, 0);
    for (int n = 0; n < 5; n++) cyc(0, 0, 0, 0);
    drain();
    clear_counts();
    for (int n = 0; n < 50; n++) cyc(0, 0, 1, 0);
    drain();
    check_int("pause_cnt_a1", cnt[1], 0);
    check_int("pause_cnt_b0", cnt[2], 12);
    clear_counts();
    for (int n = 0; n < 20; n++) cyc(0, 0, 0, 0);
    drain();
    check_int("release_first_a1", first[1], 7);
    check_int("release_first_a0", first[0], 3);
    check_int("release_first_b1", first[3], 7);

    // Resync at an odd phase, resync with pause, reset right after a pulse.
    for (int n = 0; n < 7; n++) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    drain();
    clear_counts();
    for (int n = 0; n < 6; n++) cyc(0, 0, 0, 0);
    drain();
    check_int("resync_first_a0", first[0], 4);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    drain();
    clear_counts();
    for (int n = 0; n < 12; n++) cyc(0, 0, 0, 0);
    drain();
    check_int("resync_pause_first_a0", first[0], 4);
    check_int("resync_pause_first_a1", first[1], 12);
    cyc(1, 0, 0, 0);
    drain();
    clear_counts();
    for (int n = 0; n < 12; n++) cyc(0, 0, 0, 0);
    drain();
    check_int("reset_mid_first_a0", first[0], 4);

    // Random soak.
    p  = 1'b0;
    sp = 2'd0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(29) == 0) p = ~p;
      if ($urandom_range(19) == 0) sp = 2'($urandom_range(3));
      cyc(($urandom_range(199) == 0), ($urandom_range(49) == 0), p, sp);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
